// File: rtl/conv_pkg.sv
// Shared widths, FSM state encoding and output clamp for the 3x3 convolution engine.
package conv_pkg;

   localparam int unsigned PIX_W  = 8;
   localparam int unsigned COEF_W = 8;
   localparam int unsigned PROD_W = PIX_W + COEF_W + 1;
   localparam int unsigned ACC_W  = PIX_W + COEF_W + 1 + 4;
   localparam int unsigned N_TAPS = 9;
   localparam int unsigned TAP_W  = 4;
   localparam int unsigned IMG_W  = 128;
   localparam int unsigned PAD_W  = 130;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MAC  = 2'd1,
      S_NORM = 2'd2,
      S_DONE = 2'd3
   } state_e;

   // Saturate a signed accumulator value into the unsigned pixel range.
   function automatic logic [PIX_W-1:0] clamp_u8(input logic signed [ACC_W-1:0] r);
      logic [PIX_W-1:0] res;
      if (r[ACC_W-1])                 res = '0;
      else if (|r[ACC_W-2:PIX_W])     res = '1;
      else                            res = r[PIX_W-1:0];
      return res;
   endfunction

endpackage

// File: rtl/conv3x3_engine_if.sv
// Controller <-> convolution engine handshake: start, window/kernel taps, busy/done and result.
interface conv3x3_engine_if;
   import conv_pkg::*;

   logic                       start_conv;
   logic [N_TAPS*PIX_W-1:0]    window;
   logic [N_TAPS*COEF_W-1:0]   kernel;
   logic                       busy;
   logic                       done_conv;
   logic [PIX_W-1:0]           pixel_out;

   modport master (
      output start_conv, window, kernel,
      input  busy, done_conv, pixel_out
   );

   modport slave (
      input  start_conv, window, kernel,
      output busy, done_conv, pixel_out
   );

endinterface

// File: rtl/conv_mac.sv
// Registered signed multiply-accumulate; the engine's single multiplier lives here.
module conv_mac
   import conv_pkg::*;
(
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     clr,
   input  logic                     en,
   input  logic [PIX_W-1:0]         pix,
   input  logic signed [COEF_W-1:0] coef,
   output logic signed [ACC_W-1:0]  acc
);

   logic signed [PROD_W-1:0] prod;
   logic signed [ACC_W-1:0]  acc_d;
   logic signed [ACC_W-1:0]  acc_q;

   // Pixel is unsigned: zero-extend before the signed multiply.
   always_comb begin
      prod  = PROD_W'($signed({1'b0, pix})) * PROD_W'(coef);
      acc_d = acc_q;
      if (clr)     acc_d = '0;
      else if (en) acc_d = acc_q + ACC_W'(prod);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) acc_q <= '0;
      else        acc_q <= acc_d;
   end

   assign acc = acc_q;

endmodule

// File: rtl/conv3x3_engine.sv
// 3x3 correlation engine: snapshots window/kernel on start, 9 serial MACs, shift+clamp, done pulse.
module conv3x3_engine
   import conv_pkg::*;
#(
   parameter int unsigned OUT_SHIFT = 0
)(
   input  logic              clk,
   input  logic              rst_n,
   conv3x3_engine_if.slave   bus
);

   state_e                      state_q, state_d;
   logic [TAP_W-1:0]            tap_q, tap_d;
   logic [N_TAPS*PIX_W-1:0]     win_q, win_d;
   logic [N_TAPS*COEF_W-1:0]    ker_q, ker_d;
   logic                        busy_q, busy_d;
   logic                        done_q, done_d;
   logic [PIX_W-1:0]            pix_q, pix_d;

   logic                        mac_clr, mac_en;
   logic [PIX_W-1:0]            tap_pix;
   logic signed [COEF_W-1:0]    tap_coef;
   logic signed [ACC_W-1:0]     acc;
   logic signed [ACC_W-1:0]     acc_sh;

   always_comb begin
      tap_pix  = win_q[PIX_W*tap_q +: PIX_W];
      tap_coef = $signed(ker_q[COEF_W*tap_q +: COEF_W]);
      acc_sh   = acc >>> OUT_SHIFT;
   end

   conv_mac u_mac (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (mac_clr),
      .en    (mac_en),
      .pix   (tap_pix),
      .coef  (tap_coef),
      .acc   (acc)
   );

   // Next-state and registered-output logic.
   always_comb begin
      state_d = state_q;
      tap_d   = tap_q;
      win_d   = win_q;
      ker_d   = ker_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      pix_d   = pix_q;
      mac_clr = 1'b0;
      mac_en  = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (bus.start_conv) begin
               win_d   = bus.window;
               ker_d   = bus.kernel;
               tap_d   = '0;
               mac_clr = 1'b1;
               busy_d  = 1'b1;
               state_d = S_MAC;
            end
         end
         S_MAC: begin
            mac_en = 1'b1;
            tap_d  = tap_q + TAP_W'(1);
            if (tap_q == TAP_W'(N_TAPS - 1)) state_d = S_NORM;
         end
         S_NORM: begin
            pix_d   = clamp_u8(acc_sh);
            done_d  = 1'b1;
            state_d = S_DONE;
         end
         S_DONE: begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         tap_q   <= '0;
         win_q   <= '0;
         ker_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         pix_q   <= '0;
      end else begin
         state_q <= state_d;
         tap_q   <= tap_d;
         win_q   <= win_d;
         ker_q   <= ker_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         pix_q   <= pix_d;
      end
   end

   assign bus.busy      = busy_q;
   assign bus.done_conv = done_q;
   assign bus.pixel_out = pix_q;

endmodule
